// File: rtl/ctrl_smoother.sv
// rtl/ctrl_smoother.sv - per-channel one-pole slew filter for the five ADC control words
module ctrl_smoother #(
  parameter int          FREQ_SHIFT  = 2,
  parameter int          CTRL_SHIFT  = 4,
  parameter logic [15:0] RESET_CTRL0 = 16'd90,
  parameter logic [15:0] RESET_CTRL1 = 16'd270,
  parameter logic [15:0] RESET_CTRL2 = 16'd511,
  parameter logic [15:0] RESET_CTRL3 = 16'd0,
  parameter logic [15:0] RESET_CTRL4 = 16'd0
) (
  input  logic        i_Clock,
  input  logic        reset_n,
  input  logic [15:0] i_Data0,
  input  logic [15:0] i_Data1,
  input  logic [15:0] i_Data2,
  input  logic [15:0] i_Data3,
  input  logic [15:0] i_Data4,
  input  logic        i_Data_Received,
  input  logic        i_Bypass,
  output logic [15:0] o_Ctrl0,
  output logic [15:0] o_Ctrl1,
  output logic [15:0] o_Ctrl2,
  output logic [15:0] o_Ctrl3,
  output logic [15:0] o_Ctrl4,
  output logic        o_Valid,
  output logic        o_Busy
);

  localparam int FW = 16 + FREQ_SHIFT;
  localparam int CW = 16 + CTRL_SHIFT;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE, S_LATCH} state_t;

  state_t          state_q, state_d;
  logic            prev_rx;
  logic            primed_q;
  logic            pending_q;
  logic [2:0]      ch_q;
  logic [15:0]     raw0_q;
  logic [15:0]     rawc_q  [4];
  logic [FW-1:0]   acc0_q;
  logic [CW-1:0]   acc_c_q [4];

  logic            rx_edge;
  logic [1:0]      cidx;
  logic [15:0]     raw0_in;

  logic [FW-1:0]   r0, new0;
  logic signed [FW:0] d0, step0;
  logic [FW:0]     mag0;
  logic            snap0;

  logic [CW-1:0]   rc, newc;
  logic signed [CW:0] dc, stepc;
  logic [CW:0]     magc;
  logic            snapc;

  assign rx_edge = i_Data_Received & ~prev_rx;
  assign cidx    = ch_q[1:0] - 2'd1;
  // LATCH doubles as channel 0's CALC cycle, so channel 0 reads the live input there
  assign raw0_in = (state_q == S_LATCH) ? i_Data0 : raw0_q;

  // Channel 0 filter step: snap when bypassed, unprimed or within one LSB, else slew by d/2^S
  always_comb begin
    r0    = FW'(raw0_in) << FREQ_SHIFT;
    d0    = $signed({1'b0, r0}) - $signed({1'b0, acc0_q});
    mag0  = d0[FW] ? -d0 : d0;
    step0 = d0 >>> FREQ_SHIFT;
    snap0 = i_Bypass || !primed_q || ((mag0 >> FREQ_SHIFT) == '0);
    new0  = snap0 ? r0 : acc0_q + FW'(step0);
  end

  // Shared filter step for channels 1-4, selected by the channel counter
  always_comb begin
    rc    = CW'(rawc_q[cidx]) << CTRL_SHIFT;
    dc    = $signed({1'b0, rc}) - $signed({1'b0, acc_c_q[cidx]});
    magc  = dc[CW] ? -dc : dc;
    stepc = dc >>> CTRL_SHIFT;
    snapc = i_Bypass || !primed_q || ((magc >> CTRL_SHIFT) == '0);
    newc  = snapc ? rc : acc_c_q[cidx] + CW'(stepc);
  end

  // State register
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_edge) state_d = S_CALC;
      S_CALC:  if (ch_q == 3'd4) state_d = S_DONE;
      S_DONE:  state_d = (pending_q || rx_edge) ? S_LATCH : S_IDLE;
      S_LATCH: state_d = S_CALC;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture, per-channel accumulate, and atomic publish of all five words
  always_ff @(posedge i_Clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_rx    <= 1'b0;
      primed_q   <= 1'b0;
      pending_q  <= 1'b0;
      ch_q       <= 3'd0;
      raw0_q     <= 16'd0;
      rawc_q[0]  <= 16'd0;
      rawc_q[1]  <= 16'd0;
      rawc_q[2]  <= 16'd0;
      rawc_q[3]  <= 16'd0;
      acc0_q     <= FW'(RESET_CTRL0) << FREQ_SHIFT;
      acc_c_q[0] <= CW'(RESET_CTRL1) << CTRL_SHIFT;
      acc_c_q[1] <= CW'(RESET_CTRL2) << CTRL_SHIFT;
      acc_c_q[2] <= CW'(RESET_CTRL3) << CTRL_SHIFT;
      acc_c_q[3] <= CW'(RESET_CTRL4) << CTRL_SHIFT;
      o_Ctrl0    <= RESET_CTRL0;
      o_Ctrl1    <= RESET_CTRL1;
      o_Ctrl2    <= RESET_CTRL2;
      o_Ctrl3    <= RESET_CTRL3;
      o_Ctrl4    <= RESET_CTRL4;
      o_Valid    <= 1'b0;
      o_Busy     <= 1'b0;
    end else begin
      prev_rx <= i_Data_Received;
      o_Valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_edge) begin
            raw0_q    <= i_Data0;
            rawc_q[0] <= i_Data1;
            rawc_q[1] <= i_Data2;
            rawc_q[2] <= i_Data3;
            rawc_q[3] <= i_Data4;
            o_Busy    <= 1'b1;
            ch_q      <= 3'd0;
          end
        end
        S_CALC: begin
          if (ch_q == 3'd0) acc0_q <= new0;
          else              acc_c_q[cidx] <= newc;
          ch_q <= ch_q + 3'd1;
          if (rx_edge) pending_q <= 1'b1;
        end
        S_LATCH: begin
          raw0_q    <= i_Data0;
          rawc_q[0] <= i_Data1;
          rawc_q[1] <= i_Data2;
          rawc_q[2] <= i_Data3;
          rawc_q[3] <= i_Data4;
          acc0_q    <= new0;
          ch_q      <= 3'd1;
          o_Busy    <= 1'b1;
          if (rx_edge) pending_q <= 1'b1;
        end
        S_DONE: begin
          o_Ctrl0   <= acc0_q[FW-1:FREQ_SHIFT];
          o_Ctrl1   <= acc_c_q[0][CW-1:CTRL_SHIFT];
          o_Ctrl2   <= acc_c_q[1][CW-1:CTRL_SHIFT];
          o_Ctrl3   <= acc_c_q[2][CW-1:CTRL_SHIFT];
          o_Ctrl4   <= acc_c_q[3][CW-1:CTRL_SHIFT];
          o_Valid   <= 1'b1;
          primed_q  <= 1'b1;
          // A queued frame restarts immediately, so busy does not drop between back-to-back results
          o_Busy    <= pending_q || rx_edge;
          pending_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_smoother.sv
// tb/tb_ctrl_smoother.sv - directed self-checking bench for ctrl_smoother
module tb_ctrl_smoother;

  logic        clk;
  logic        reset_n;
  logic [15:0] data0, data1, data2, data3, data4;
  logic        rx;
  logic        bypass;
  logic [15:0] ctrl0, ctrl1, ctrl2, ctrl3, ctrl4;
  logic        valid;
  logic        busy;

  int tests = 0;
  int fails = 0;

  ctrl_smoother dut (
    .i_Clock         (clk),
    .reset_n         (reset_n),
    .i_Data0         (data0),
    .i_Data1         (data1),
    .i_Data2         (data2),
    .i_Data3         (data3),
    .i_Data4         (data4),
    .i_Data_Received (rx),
    .i_Bypass        (bypass),
    .o_Ctrl0         (ctrl0),
    .o_Ctrl1         (ctrl1),
    .o_Ctrl2         (ctrl2),
    .o_Ctrl3         (ctrl3),
    .o_Ctrl4         (ctrl4),
    .o_Valid         (valid),
    .o_Busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [15:0] a, b, c, d, e);
    data0 = a; data1 = b; data2 = c; data3 = d; data4 = e;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] a, b, c, d, e);
    chk({tag, "_c0"}, ctrl0, a);
    chk({tag, "_c1"}, ctrl1, b);
    chk({tag, "_c2"}, ctrl2, c);
    chk({tag, "_c3"}, ctrl3, d);
    chk({tag, "_c4"}, ctrl4, e);
  endtask

  // One isolated frame: valid must appear exactly 6 edges after the sampled rx edge
  task automatic send_frame(input logic [15:0] a, b, c, d, e);
    set_data(a, b, c, d, e);
    rx = 1'b1;
    step();
    rx = 1'b0;
    chk("busy_after_capture", busy, 1);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("valid_early", valid, 0);
    end
    step();
    chk("valid_at_n6", valid, 1);
    chk("busy_cleared", busy, 0);
  endtask

  int          nv;
  logic [15:0] prev0, prev1;

  initial begin
    reset_n = 1'b0;
    rx      = 1'b0;
    bypass  = 1'b0;
    set_data(0, 0, 0, 0, 0);
    step();
    step();
    chk_outs("reset", 90, 270, 511, 0, 0);
    chk("reset_valid", valid, 0);
    chk("reset_busy", busy, 0);
    reset_n = 1'b1;
    step();

    // First frame snaps straight to the raw values
    send_frame(1000, 100, 200, 300, 40);
    chk_outs("prime", 1000, 100, 200, 300, 40);

    // Level held high produces exactly one result
    rx = 1'b1;
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (valid) nv++;
    end
    rx = 1'b0;
    step();
    chk("level_one_pulse", nv, 1);

    // Bypass frame parks channel 1 at 0
    bypass = 1'b1;
    send_frame(1000, 0, 200, 300, 40);
    chk_outs("bypass_zero", 1000, 0, 200, 300, 40);
    bypass = 1'b0;

    // Slew: ch0 1000->0 with 1/4, ch1 0->1600 with 1/16
    send_frame(0, 1600, 200, 300, 40);
    chk_outs("slew1", 750, 100, 200, 300, 40);
    send_frame(0, 1600, 200, 300, 40);
    chk_outs("slew2", 562, 193, 200, 300, 40);
    send_frame(0, 1600, 200, 300, 40);
    chk_outs("slew3", 421, 281, 200, 300, 40);

    // Run to convergence: monotonic, bounded, exact final values
    for (int i = 0; i < 300 && !(ctrl0 == 16'd0 && ctrl1 == 16'd1600); i++) begin
      prev0 = ctrl0;
      prev1 = ctrl1;
      send_frame(0, 1600, 200, 300, 40);
      chk("mono_ch1", (ctrl1 >= prev1) && (ctrl1 <= 16'd1600), 1);
      chk("mono_ch0", ctrl0 <= prev0, 1);
    end
    chk("conv_ch0", ctrl0, 0);
    chk("conv_ch1", ctrl1, 1600);

    // Bypass jump 0 -> 1600 lands in one frame
    bypass = 1'b1;
    send_frame(0, 0, 200, 300, 40);
    chk("bypass_c1_low", ctrl1, 0);
    send_frame(0, 1600, 200, 300, 40);
    chk("bypass_c1_jump", ctrl1, 1600);

    // Back-to-back frames: second edge 2 cycles after the first, a third merges into pending
    set_data(7, 7, 7, 7, 7);
    rx = 1'b1;
    step();                         // N
    rx = 1'b0;
    step();                         // N+1
    set_data(5000, 5000, 5000, 5000, 5000);
    rx = 1'b1;
    step();                         // N+2
    rx = 1'b0;
    step();                         // N+3
    rx = 1'b1;
    step();                         // N+4
    rx = 1'b0;
    step();                         // N+5
    chk("pend_valid_n5", valid, 0);
    chk("pend_busy_n5", busy, 1);
    step();                         // N+6
    chk("pend_valid1", valid, 1);
    chk_outs("pend_first", 7, 7, 7, 7, 7);
    for (int k = 7; k <= 11; k++) begin
      step();
      chk("pend_gap_valid", valid, 0);
      chk("pend_gap_busy", busy, 1);
    end
    step();                         // N+12
    chk("pend_valid2", valid, 1);
    chk_outs("pend_second", 5000, 5000, 5000, 5000, 5000);
    chk("pend_busy_end", busy, 0);
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (valid) nv++;
    end
    chk("pend_no_third", nv, 0);

    // Reset during CALC with a frame pending
    set_data(1, 2, 3, 4, 5);
    rx = 1'b1;
    step();
    rx = 1'b0;
    step();
    rx = 1'b1;
    step();
    rx = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("midreset", 90, 270, 511, 0, 0);
    chk("midreset_valid", valid, 0);
    chk("midreset_busy", busy, 0);
    step();
    reset_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (valid) nv++;
    end
    chk("midreset_pending_dropped", nv, 0);

    // Primed cleared by reset: next frame snaps even without bypass
    bypass = 1'b0;
    send_frame(1234, 2345, 3456, 4567, 5678);
    chk_outs("reprime", 1234, 2345, 3456, 4567, 5678);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
